genius_seq_ctrl: RTL and testbench

Round sequencer for the GENIUS sequence register: owns the write port (enable + data) of the 64-bit, 16-nibble sequence register and reads back its contents. Each round it appends one random nibble, plays the stored sequence out one nibble at a time, then checks the player's entries against it. It sits between the random source, the button decoder and the display driver.

---
 rtl/genius_pkg.sv | 23 ++
 rtl/genius_seq_ctrl_if.sv | 25 ++
 rtl/genius_timer.sv | 25 ++
 rtl/genius_seq_ctrl.sv | 89 ++++++++
 tb/tb_genius_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// genius_pkg: shared types, sizes and nibble helper for the GENIUS sequencer
package genius_pkg;
  localparam int SEQ_NIBBLES = 16;
  localparam int NIB_W = 4;
  localparam int SEQ_W = SEQ_NIBBLES * NIB_W;
  localparam int RND_W = $clog2(SEQ_NIBBLES + 1);
  typedef enum logic [3:0] {IDLE, CLEAR, APPEND, SETTLE, SHOW, GAP, INPUT, WIN, FAIL} state_t;
  typedef struct packed {
    logic reg_e;
    logic [SEQ_W-1:0] reg_data;
    logic show_valid;
    logic [NIB_W-1:0] show_nib;
    logic [RND_W-1:0] round;
    logic busy;
    logic win;
    logic fail;
  } out_t;
  function automatic logic [NIB_W-1:0] nib(input logic [SEQ_W-1:0] q, input logic [NIB_W-1:0] i);
    logic [SEQ_W-1:0] t;
    t = q << (NIB_W * i);
    return t[SEQ_W-1 -: NIB_W];
  endfunction
endpackage

// File: rtl/genius_seq_ctrl_if.sv
// genius_seq_ctrl_if: game inputs, sequence register port and display/status outputs
interface genius_seq_ctrl_if;
  import genius_pkg::*;
  logic start;
  logic [NIB_W-1:0] rnd;
  logic btn_valid;
  logic [NIB_W-1:0] btn;
  logic [SEQ_W-1:0] reg_q;
  logic reg_E;
  logic [SEQ_W-1:0] reg_data;
  logic show_valid;
  logic [NIB_W-1:0] show_nib;
  logic [RND_W-1:0] round;
  logic busy;
  logic win;
  logic fail;
  modport master (
    input start, rnd, btn_valid, btn, reg_q,
    output reg_E, reg_data, show_valid, show_nib, round, busy, win, fail
  );
  modport slave (
    output start, rnd, btn_valid, btn, reg_q,
    input reg_E, reg_data, show_valid, show_nib, round, busy, win, fail
  );
endinterface

// File: rtl/genius_timer.sv
// genius_timer: loadable down-counter; expire pulses once when a loaded count reaches zero
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         R,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expire
);
  logic [W-1:0] cnt;
  logic run;
  always_ff @(posedge clk or negedge R)
    if (!R) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= val;
      run <= 1'b1;
    end else if (run) begin
      cnt <= cnt - (cnt != '0 ? 1'b1 : 1'b0);
      run <= cnt != '0;
    end
  assign expire = run && cnt == '0;
endmodule

// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl: per-round append, playback and player check for the GENIUS sequence register
module genius_seq_ctrl
  import genius_pkg::*;
#(
  parameter int SHOW_CYC = 25_000_000,
  parameter int GAP_CYC = 12_500_000,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input logic clk,
  input logic R,
  genius_seq_ctrl_if.master bus
);
  localparam int MAX_CYC = TIMEOUT_CYC > SHOW_CYC ? (TIMEOUT_CYC > GAP_CYC ? TIMEOUT_CYC : GAP_CYC)
                                                  : (SHOW_CYC > GAP_CYC ? SHOW_CYC : GAP_CYC);
  localparam int TW = $clog2(MAX_CYC) > 0 ? $clog2(MAX_CYC) : 1;
  state_t state, nstate;
  logic [NIB_W-1:0] idx, idx_d;
  logic [5:0] sh;
  logic [TW-1:0] load_val;
  logic expire, load, hit, more;
  out_t o, o_d;
  assign hit = bus.btn == nib(bus.reg_q, idx);
  assign more = {1'b0, idx} + 5'd1 < bus.round;
  genius_timer #(.W(TW)) u_timer (
    .clk(clk),
    .R(R),
    .load(load),
    .val(load_val),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge R)
    if (!R) begin
      state <= IDLE;
      idx <= '0;
      o <= '0;
    end else begin
      state <= nstate;
      idx <= idx_d;
      o <= o_d;
    end
  always_comb begin
    nstate = state;
    idx_d = idx;
    case (state)
      IDLE, WIN, FAIL: nstate = bus.start ? CLEAR : state;
      CLEAR: nstate = APPEND;
      APPEND: nstate = SETTLE;
      SETTLE: begin
        nstate = SHOW;
        idx_d = '0;
      end
      SHOW: nstate = expire ? GAP : SHOW;
      GAP: if (expire) begin
        nstate = more ? SHOW : INPUT;
        idx_d = more ? idx + 1'b1 : '0;
      end
      INPUT: if (bus.btn_valid) begin
        nstate = !hit ? FAIL : more ? INPUT : bus.round == RND_W'(SEQ_NIBBLES) ? WIN : APPEND;
        idx_d = hit && more ? idx + 1'b1 : '0;
      end else if (expire) nstate = FAIL;
      default: nstate = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they line up with the state they describe
  always_comb begin
    load = nstate != state || (state == INPUT && bus.btn_valid);
    load_val = nstate == SHOW ? TW'(SHOW_CYC - 1) : nstate == GAP ? TW'(GAP_CYC - 1)
             : nstate == INPUT ? TW'(TIMEOUT_CYC - 1) : '0;
    sh = 6'(SEQ_W - NIB_W - NIB_W * int'(bus.round));
    o_d = '0;
    o_d.reg_e = nstate == CLEAR || nstate == APPEND;
    // Coming from CLEAR the register write has not landed yet, but its contents are known to be zero
    o_d.reg_data = nstate == APPEND ? (state == CLEAR ? '0 : bus.reg_q) | (SEQ_W'(bus.rnd) << sh) : '0;
    o_d.show_valid = nstate == SHOW;
    o_d.show_nib = nstate == SHOW ? nib(bus.reg_q, idx_d) : '0;
    o_d.round = nstate == CLEAR ? '0 : nstate == APPEND ? bus.round + 1'b1 : bus.round;
    o_d.busy = !(nstate inside {IDLE, WIN, FAIL});
    o_d.win = nstate == WIN;
    o_d.fail = nstate == FAIL;
  end
  assign bus.reg_E = o.reg_e;
  assign bus.reg_data = o.reg_data;
  assign bus.show_valid = o.show_valid;
  assign bus.show_nib = o.show_nib;
  assign bus.round = o.round;
  assign bus.busy = o.busy;
  assign bus.win = o.win;
  assign bus.fail = o.fail;
endmodule

// File: tb/tb_genius_seq_ctrl.sv
// tb_genius_seq_ctrl: randomized game scenarios checked against a nibble-queue model of the game
module tb_genius_seq_ctrl;
  localparam int SHOW = 4, GAP = 2, TMO = 20;
  logic clk = 1'b0;
  logic R = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [3:0] seq[$];
  genius_seq_ctrl_if bus();
  genius_seq_ctrl #(.SHOW_CYC(SHOW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .R(R),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge R)
    if (!R) bus.reg_q <= '0;
    else if (bus.reg_E) bus.reg_q <= bus.reg_data;

  function automatic logic [63:0] exp_reg();
    logic [63:0] v = '0;
    foreach (seq[i]) v |= 64'(seq[i]) << (60 - 4 * i);
    return v;
  endfunction

  function automatic logic [77:0] outs();
    return {bus.reg_E, bus.reg_data, bus.show_valid, bus.show_nib, bus.round, bus.busy, bus.win, bus.fail};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] b);
    bus.btn_valid = 1'b1;
    bus.btn = b;
    tick();
    bus.btn_valid = 1'b0;
  endtask

  task automatic observe_round(input logic [3:0] r, input bit poke);
    bus.rnd = r;
    seq.push_back(r);
    tick();
    bus.btn_valid = 1'b0;
    n_chk++;
    if (bus.reg_E !== 1'b1 || bus.reg_data !== exp_reg()) begin
      n_fail++;
      $display("FAIL append: reg_E=%0b reg_data=%h, expected 1 and %h", bus.reg_E, bus.reg_data, exp_reg());
    end
    n_chk++;
    if (bus.round !== 5'(seq.size())) begin
      n_fail++;
      $display("FAIL round: got %0d, expected %0d", bus.round, seq.size());
    end
    tick();
    n_chk++;
    if (bus.reg_E !== 1'b0 || bus.show_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL settle: reg_E=%0b show_valid=%0b, expected 0 0", bus.reg_E, bus.show_valid);
    end
    foreach (seq[i]) begin
      for (int c = 0; c < SHOW; c++) begin
        tick();
        bus.start = 1'b0;
        bus.btn_valid = 1'b0;
        n_chk++;
        if (bus.show_valid !== 1'b1 || bus.show_nib !== seq[i]) begin
          n_fail++;
          $display("FAIL show[%0d] cyc %0d: valid=%0b nib=%h, expected 1 %h", i, c, bus.show_valid, bus.show_nib, seq[i]);
        end
        if (poke && c == 0) begin
          bus.start = 1'b1;
          bus.btn_valid = 1'b1;
          bus.btn = ~seq[i];
        end
      end
      for (int c = 0; c < GAP; c++) begin
        tick();
        bus.start = 1'b0;
        bus.btn_valid = 1'b0;
        n_chk++;
        if (bus.show_valid !== 1'b0 || bus.show_nib !== 4'h0) begin
          n_fail++;
          $display("FAIL gap[%0d]: valid=%0b nib=%h, expected 0 0", i, bus.show_valid, bus.show_nib);
        end
      end
    end
    tick();
    n_chk++;
    if (bus.busy !== 1'b1 || bus.show_valid !== 1'b0 || bus.fail !== 1'b0 || bus.win !== 1'b0) begin
      n_fail++;
      $display("FAIL input entry: busy=%0b show=%0b fail=%0b win=%0b, expected 1 0 0 0",
               bus.busy, bus.show_valid, bus.fail, bus.win);
    end
  endtask

  task automatic start_game(input logic [3:0] r, input bit poke);
    seq.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_chk++;
    if (bus.reg_E !== 1'b1 || bus.reg_data !== 64'h0 || bus.round !== 5'd0 || bus.busy !== 1'b1
        || bus.win !== 1'b0 || bus.fail !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: reg_E=%0b data=%h round=%0d busy=%0b win=%0b fail=%0b, expected 1 0 0 1 0 0",
               bus.reg_E, bus.reg_data, bus.round, bus.busy, bus.win, bus.fail);
    end
    observe_round(r, poke);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn = '0;
    bus.rnd = '0;
    #12;
    n_chk++;
    if (outs() !== 78'h0) begin
      n_fail++;
      $display("FAIL reset hold: outputs=%h, expected 0", outs());
    end
    @(negedge clk);
    R = 1'b1;
    tick();
    n_chk++;
    if (outs() !== 78'h0) begin
      n_fail++;
      $display("FAIL reset release: outputs=%h, expected 0", outs());
    end
  endtask

  task automatic test_first_round();
    start_game(4'h3, 1'b0);
  endtask

  task automatic test_mismatch();
    bus.btn_valid = 1'b1;
    bus.btn = seq[0];
    observe_round(4'hA, 1'b1);
    enter(seq[0]);
    n_chk++;
    if (bus.fail !== 1'b0 || bus.busy !== 1'b1 || bus.reg_E !== 1'b0) begin
      n_fail++;
      $display("FAIL partial match: fail=%0b busy=%0b reg_E=%0b, expected 0 1 0", bus.fail, bus.busy, bus.reg_E);
    end
    enter(4'h5);
    n_chk++;
    if (bus.fail !== 1'b1 || bus.busy !== 1'b0 || bus.reg_E !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch: fail=%0b busy=%0b reg_E=%0b, expected 1 0 0", bus.fail, bus.busy, bus.reg_E);
    end
    repeat (3) tick();
    n_chk++;
    if (bus.fail !== 1'b1 || bus.reg_E !== 1'b0) begin
      n_fail++;
      $display("FAIL fail hold: fail=%0b reg_E=%0b, expected 1 0", bus.fail, bus.reg_E);
    end
  endtask

  task automatic test_timeout();
    start_game(4'($urandom), 1'b0);
    repeat (TMO - 1) tick();
    n_chk++;
    if (bus.fail !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early timeout: fail=%0b busy=%0b, expected 0 1", bus.fail, bus.busy);
    end
    tick();
    n_chk++;
    if (bus.fail !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: fail=%0b busy=%0b, expected 1 0", bus.fail, bus.busy);
    end
    start_game(4'($urandom), 1'b0);
    repeat (TMO - 1) tick();
    bus.btn_valid = 1'b1;
    bus.btn = seq[0];
    observe_round(4'($urandom), 1'b0);
    repeat (14) tick();
    enter(seq[0]);
    repeat (TMO - 1) tick();
    bus.btn_valid = 1'b1;
    bus.btn = seq[1];
    observe_round(4'($urandom), 1'b0);
    enter(seq[0] ^ 4'h1);
    n_chk++;
    if (bus.fail !== 1'b1 || bus.round !== 5'd3) begin
      n_fail++;
      $display("FAIL timeout game end: fail=%0b round=%0d, expected 1 3", bus.fail, bus.round);
    end
  endtask

  task automatic test_win();
    start_game(4'($urandom), 1'b0);
    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < k - 1; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        enter(seq[i]);
        n_chk++;
        if (bus.fail !== 1'b0 || bus.busy !== 1'b1 || bus.reg_E !== 1'b0) begin
          n_fail++;
          $display("FAIL entry r%0d i%0d: fail=%0b busy=%0b reg_E=%0b, expected 0 1 0", k, i, bus.fail, bus.busy, bus.reg_E);
        end
      end
      repeat ($urandom_range(0, 4)) tick();
      bus.btn_valid = 1'b1;
      bus.btn = seq[k-1];
      if (k < 16) observe_round(4'($urandom), 1'b0);
      else begin
        tick();
        bus.btn_valid = 1'b0;
      end
    end
    n_chk++;
    if (bus.win !== 1'b1 || bus.round !== 5'd16 || bus.busy !== 1'b0 || bus.reg_E !== 1'b0 || bus.fail !== 1'b0) begin
      n_fail++;
      $display("FAIL win: win=%0b round=%0d busy=%0b reg_E=%0b fail=%0b, expected 1 16 0 0 0",
               bus.win, bus.round, bus.busy, bus.reg_E, bus.fail);
    end
    repeat (5) tick();
    n_chk++;
    if (bus.win !== 1'b1 || bus.reg_E !== 1'b0 || bus.reg_q !== exp_reg()) begin
      n_fail++;
      $display("FAIL win hold: win=%0b reg_E=%0b reg_q=%h, expected 1 0 %h", bus.win, bus.reg_E, bus.reg_q, exp_reg());
    end
    start_game(4'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    enter(seq[0] ^ 4'h8);
    seq.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.rnd = 4'h7;
    repeat (3) tick();
    n_chk++;
    if (bus.show_valid !== 1'b1 || bus.show_nib !== 4'h7) begin
      n_fail++;
      $display("FAIL pre-reset show: valid=%0b nib=%h, expected 1 7", bus.show_valid, bus.show_nib);
    end
    #2 R = 1'b0;
    #1;
    n_chk++;
    if (outs() !== 78'h0) begin
      n_fail++;
      $display("FAIL async reset: outputs=%h, expected 0", outs());
    end
    @(negedge clk);
    R = 1'b1;
    tick();
    n_chk++;
    if (outs() !== 78'h0) begin
      n_fail++;
      $display("FAIL post-reset idle: outputs=%h, expected 0", outs());
    end
    start_game(4'($urandom), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_round();
    test_mismatch();
    test_timeout();
    test_win();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
